// File: rtl/ftf_encode_scheduler_if.sv
// Bus between the lane sources, the shared FTF encoder and the CAC bus driver.
// The scheduler takes the slave side; the surrounding environment the master side.
interface ftf_encode_scheduler_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 19,
    parameter int SRC_W  = 2
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [DATA_W-1:0]       enc_datain;
    logic [27:0]             enc_codeout;
    logic                    out_valid;
    logic [27:0]             out_code;
    logic [SRC_W-1:0]        out_src;
    logic                    out_ready;
    logic                    busy;
    logic [15:0]             enc_count;

    modport master (
        output req_valid, req_data, enc_codeout, out_ready,
        input  req_ready, enc_datain, out_valid, out_code, out_src, busy, enc_count
    );

    modport slave (
        input  req_valid, req_data, enc_codeout, out_ready,
        output req_ready, enc_datain, out_valid, out_code, out_src, busy, enc_count
    );
endinterface

// File: rtl/ftf_encode_scheduler.sv
// Round-robin sharing of one registered FTF_encoder_28 between N_REQ lane sources,
// with source tagging and a credit-protected output FIFO.
module ftf_encode_scheduler #(
    parameter int N_REQ      = 4,
    parameter int DATA_W     = 19,
    parameter int OBUF_DEPTH = 4
) (
    input  logic                  clock,
    input  logic                  rst_n,
    ftf_encode_scheduler_if.slave bus
);
    localparam int SRC_W = $clog2(N_REQ);
    localparam int PTR_W = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;
    localparam int CNT_W = $clog2(OBUF_DEPTH + 1);
    localparam int OCC_W = CNT_W + 1;
    localparam logic [OCC_W-1:0] DEPTH_C  = OCC_W'(OBUF_DEPTH);
    localparam logic [SRC_W-1:0] LAST_SRC = SRC_W'(N_REQ - 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(OBUF_DEPTH - 1);

    logic                    r_active;
    logic [SRC_W-1:0]        r_rr_ptr;
    logic                    r_v1;
    logic                    r_v2;
    logic [SRC_W-1:0]        r_tag1;
    logic [SRC_W-1:0]        r_tag2;
    logic [DATA_W-1:0]       r_datain;
    logic [28+SRC_W-1:0]     r_mem [OBUF_DEPTH];
    logic [PTR_W-1:0]        r_wr_ptr;
    logic [PTR_W-1:0]        r_rd_ptr;
    logic [CNT_W-1:0]        r_fifo_count;
    logic [15:0]             r_enc_count;

    logic                    w_grant_any;
    logic [SRC_W-1:0]        w_grant_idx;
    logic [OCC_W-1:0]        w_occ;
    logic                    w_out_valid;
    logic                    w_pop;
    logic                    w_allow;
    logic                    w_accept;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // First valid requester at or after r_rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        w_grant_any = 1'b0;
        w_grant_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!w_grant_any && bus.req_valid[(int'(r_rr_ptr) + k) % N_REQ]) begin
                w_grant_any = 1'b1;
                w_grant_idx = SRC_W'((int'(r_rr_ptr) + k) % N_REQ);
            end
        end
    end

    // Words in the encoder pipeline already own a FIFO slot, so the FIFO can never overflow.
    assign w_out_valid = (r_fifo_count != '0);
    assign w_pop       = w_out_valid & bus.out_ready;
    assign w_occ       = OCC_W'(r_fifo_count) + OCC_W'(r_v1) + OCC_W'(r_v2);
    assign w_allow     = r_active & ((w_occ < DEPTH_C) | ((w_occ == DEPTH_C) & w_pop));
    assign w_accept    = w_allow & w_grant_any;

    assign bus.req_ready  = w_accept ? (N_REQ'(1) << w_grant_idx) : '0;
    assign bus.enc_datain = r_datain;
    assign bus.out_valid  = w_out_valid;
    assign {bus.out_code, bus.out_src} = r_mem[r_rd_ptr];
    assign bus.busy       = r_v1 | r_v2 | w_out_valid;
    assign bus.enc_count  = r_enc_count;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_active     <= 1'b0;
            r_rr_ptr     <= '0;
            r_v1         <= 1'b0;
            r_v2         <= 1'b0;
            r_tag1       <= '0;
            r_tag2       <= '0;
            r_datain     <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_fifo_count <= '0;
            r_enc_count  <= '0;
        end else begin
            r_active <= 1'b1;
            r_v1     <= w_accept;
            r_v2     <= r_v1;
            r_tag2   <= r_tag1;
            if (w_accept) begin
                r_datain <= bus.req_data[w_grant_idx*DATA_W +: DATA_W];
                r_tag1   <= w_grant_idx;
                r_rr_ptr <= (w_grant_idx == LAST_SRC) ? '0 : w_grant_idx + 1'b1;
            end
            if (r_v2) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr    <= ptr_inc(r_rd_ptr);
                r_enc_count <= r_enc_count + 16'd1;
            end
            if (r_v2 && !w_pop) begin
                r_fifo_count <= r_fifo_count + 1'b1;
            end else if (!r_v2 && w_pop) begin
                r_fifo_count <= r_fifo_count - 1'b1;
            end
        end
    end

    // enc_codeout belongs to the word that was on enc_datain one cycle earlier (tag2).
    always_ff @(posedge clock) begin
        if (r_v2) begin
            r_mem[r_wr_ptr] <= {bus.enc_codeout, r_tag2};
        end
    end
endmodule

// File: tb/tb_ftf_encode_scheduler.sv
// Directed and random checks of the shared-encoder scheduler, with a registered
// Fibonacci-weighted encoder model standing in for FTF_encoder_28.
module tb_ftf_encode_scheduler;
    localparam int N  = 4;
    localparam int DW = 19;

    logic clock;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    ftf_encode_scheduler_if #(.N_REQ(N), .DATA_W(DW), .SRC_W(2)) bus0 ();
    ftf_encode_scheduler_if #(.N_REQ(N), .DATA_W(DW), .SRC_W(2)) bus1 ();

    ftf_encode_scheduler #(.N_REQ(N), .DATA_W(DW), .OBUF_DEPTH(4)) dut0 (
        .clock (clock),
        .rst_n (rst_n),
        .bus   (bus0.slave)
    );

    ftf_encode_scheduler #(.N_REQ(N), .DATA_W(DW), .OBUF_DEPTH(1)) dut1 (
        .clock (clock),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Golden codeword: greedy representation over weights 1,2,3,5,8,... (no two adjacent ones).
    function automatic logic [27:0] ftf_enc(input logic [DW-1:0] d);
        logic [27:0] c;
        int unsigned w [28];
        int unsigned rem;
        c    = '0;
        w[0] = 1;
        w[1] = 2;
        for (int k = 2; k < 28; k++) w[k] = w[k-1] + w[k-2];
        rem = d;
        for (int k = 27; k >= 0; k--) begin
            if (rem >= w[k]) begin
                c[k] = 1'b1;
                rem  = rem - w[k];
            end
        end
        return c;
    endfunction

    always_ff @(posedge clock) begin
        bus0.enc_codeout <= ftf_enc(bus0.enc_datain);
        bus1.enc_codeout <= ftf_enc(bus1.enc_datain);
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        bus0.req_valid = 4'hF;
        bus0.out_ready = 1'b1;
        repeat (3) cyc();
        #1;
        checks++; if (bus0.req_ready !== 4'h0) begin errors++; $display("FAIL reset_req_ready: got %b expected 0000", bus0.req_ready); end
        checks++; if (bus0.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus0.out_valid); end
        checks++; if (bus0.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus0.busy); end
        checks++; if (bus0.enc_count !== 16'd0) begin errors++; $display("FAIL reset_enc_count: got %0d expected 0", bus0.enc_count); end
        checks++; if (bus0.enc_datain !== '0) begin errors++; $display("FAIL reset_enc_datain: got %h expected 0", bus0.enc_datain); end
        bus0.req_valid = 4'h0;
        @(negedge clock);
        rst_n = 1'b1;
        $display("reset released");
    endtask

    task automatic test_single();
        cyc();
        bus0.req_valid = 4'b0001;
        bus0.req_data  = '0;
        #1;
        checks++; if (bus0.req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready: got %b expected 0001", bus0.req_ready); end
        for (int c = 1; c <= 3; c++) begin
            cyc();
            bus0.req_valid = 4'b0000;
            #1;
            if (c < 3) begin
                checks++; if (bus0.out_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid c+%0d: got %b expected 0", c, bus0.out_valid); end
            end else begin
                checks++; if (bus0.out_valid !== 1'b1 || bus0.out_code !== 28'h0 || bus0.out_src !== 2'd0) begin
                    errors++; $display("FAIL single_out: got v=%b code=%h src=%0d expected v=1 code=0000000 src=0", bus0.out_valid, bus0.out_code, bus0.out_src);
                end
                $display("single: out src=%0d code=%h", bus0.out_src, bus0.out_code);
            end
        end
        cyc();
        #1;
        checks++; if (bus0.enc_count !== 16'd1) begin errors++; $display("FAIL single_enc_count: got %0d expected 1", bus0.enc_count); end
        checks++; if (bus0.busy !== 1'b0) begin errors++; $display("FAIL single_busy: got %b expected 0", bus0.busy); end
    endtask

    // rr_ptr is 1 after test_single, so grants run 1,2,3,0,...
    task automatic test_round_robin();
        logic [29:0] q[$];
        logic [29:0] e;
        int g;
        bus0.out_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            cyc();
            bus0.req_valid = (k < 8) ? 4'hF : 4'h0;
            for (int i = 0; i < N; i++) bus0.req_data[i*DW +: DW] = DW'((k*4 + i)*12345 + 7);
            #1;
            if (k < 8) begin
                g = (1 + k) % N;
                checks++; if (bus0.req_ready !== 4'(1 << g)) begin errors++; $display("FAIL rr_grant k=%0d: got %b expected %b", k, bus0.req_ready, 4'(1 << g)); end
                q.push_back({2'(g), ftf_enc(bus0.req_data[g*DW +: DW])});
            end
            if (k >= 3 && k < 11) begin
                e = q.pop_front();
                checks++; if (bus0.out_valid !== 1'b1 || {bus0.out_src, bus0.out_code} !== e) begin
                    errors++; $display("FAIL rr_out k=%0d: got v=%b src=%0d code=%h expected v=1 src=%0d code=%h", k, bus0.out_valid, bus0.out_src, bus0.out_code, e[29:28], e[27:0]);
                end
                $display("rr: out src=%0d code=%h", bus0.out_src, bus0.out_code);
            end else if (k == 11) begin
                checks++; if (bus0.out_valid !== 1'b0) begin errors++; $display("FAIL rr_idle: got %b expected 0", bus0.out_valid); end
            end
        end
    endtask

    // rr_ptr is 1 again; four accepts fill the credit, then the FIFO is drained.
    task automatic test_backpressure();
        logic [29:0] q[$];
        logic [29:0] e;
        logic [3:0]  exp_rdy;
        int g;
        int acc = 0;
        bus0.out_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            cyc();
            bus0.req_valid = 4'hF;
            for (int i = 0; i < N; i++) bus0.req_data[i*DW +: DW] = DW'(32'h3A5C1 ^ (k*977 + i*31));
            #1;
            g       = (1 + k) % N;
            exp_rdy = (k < 4) ? 4'(1 << g) : 4'h0;
            checks++; if (bus0.req_ready !== exp_rdy) begin errors++; $display("FAIL bp_grant k=%0d: got %b expected %b", k, bus0.req_ready, exp_rdy); end
            if (bus0.req_ready != 4'h0) acc++;
            if (k < 4) q.push_back({2'(g), ftf_enc(bus0.req_data[g*DW +: DW])});
        end
        checks++; if (acc !== 4) begin errors++; $display("FAIL bp_accepts: got %0d expected 4", acc); end
        for (int k = 0; k < 4; k++) begin
            cyc();
            bus0.req_valid = 4'h0;
            bus0.out_ready = 1'b1;
            #1;
            e = q.pop_front();
            checks++; if (bus0.out_valid !== 1'b1 || {bus0.out_src, bus0.out_code} !== e) begin
                errors++; $display("FAIL bp_drain %0d: got v=%b src=%0d code=%h expected v=1 src=%0d code=%h", k, bus0.out_valid, bus0.out_src, bus0.out_code, e[29:28], e[27:0]);
            end
            $display("bp: out src=%0d code=%h", bus0.out_src, bus0.out_code);
        end
        cyc();
        #1;
        checks++; if (bus0.out_valid !== 1'b0 || bus0.busy !== 1'b0) begin errors++; $display("FAIL bp_empty: got v=%b busy=%b expected 0 0", bus0.out_valid, bus0.busy); end
        bus0.req_valid = 4'hF;
        #1;
        checks++; if (bus0.req_ready !== 4'b0010) begin errors++; $display("FAIL bp_resume: got %b expected 0010", bus0.req_ready); end
        for (int c = 1; c <= 3; c++) begin
            cyc();
            bus0.req_valid = 4'h0;
        end
        #1;
        checks++; if (bus0.out_valid !== 1'b1 || bus0.out_src !== 2'd1) begin errors++; $display("FAIL bp_resume_out: got v=%b src=%0d expected v=1 src=1", bus0.out_valid, bus0.out_src); end
    endtask

    // Requester 2 alone moves rr_ptr to 3; requester 1 then joins and must alternate.
    task automatic test_rr_join();
        int exp_g [4] = '{2, 1, 2, 1};
        logic [3:0] exp_rdy;
        logic [DW-1:0] w;
        bus0.out_ready = 1'b1;
        for (int i = 0; i < N; i++) bus0.req_data[i*DW +: DW] = DW'(32'h11111 * (i + 1));
        for (int k = 0; k < 8; k++) begin
            cyc();
            bus0.req_valid = (k == 0) ? 4'b0100 : (k < 4) ? 4'b0110 : 4'b0000;
            #1;
            if (k < 4) begin
                exp_rdy = 4'(1 << exp_g[k]);
                checks++; if (bus0.req_ready !== exp_rdy) begin errors++; $display("FAIL join_grant k=%0d: got %b expected %b", k, bus0.req_ready, exp_rdy); end
            end
            if (k >= 3 && k < 7) begin
                w = DW'(32'h11111 * (exp_g[k-3] + 1));
                checks++; if (bus0.out_valid !== 1'b1 || bus0.out_src !== 2'(exp_g[k-3]) || bus0.out_code !== ftf_enc(w)) begin
                    errors++; $display("FAIL join_out k=%0d: got v=%b src=%0d code=%h expected v=1 src=%0d code=%h", k, bus0.out_valid, bus0.out_src, bus0.out_code, exp_g[k-3], ftf_enc(w));
                end
                $display("join: out src=%0d code=%h", bus0.out_src, bus0.out_code);
            end
        end
    endtask

    task automatic test_reset_midflight();
        bus0.out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cyc();
            bus0.req_valid = 4'hF;
            #1;
            checks++; if (bus0.req_ready === 4'h0) begin errors++; $display("FAIL mid_fill k=%0d: got %b expected one-hot", k, bus0.req_ready); end
        end
        cyc();
        bus0.req_valid = 4'h0;
        #1;
        checks++; if (bus0.busy !== 1'b1 || bus0.out_valid !== 1'b1) begin errors++; $display("FAIL mid_pre: got busy=%b v=%b expected 1 1", bus0.busy, bus0.out_valid); end
        checks++; if (bus0.enc_count !== 16'd18) begin errors++; $display("FAIL mid_count_pre: got %0d expected 18", bus0.enc_count); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus0.out_valid !== 1'b0 || bus0.busy !== 1'b0 || bus0.enc_count !== 16'd0) begin
            errors++; $display("FAIL mid_reset: got v=%b busy=%b count=%0d expected 0 0 0", bus0.out_valid, bus0.busy, bus0.enc_count);
        end
        @(posedge clock);
        @(negedge clock);
        rst_n          = 1'b1;
        bus0.out_ready = 1'b1;
        cyc();
        bus0.req_valid = 4'b1000;
        bus0.req_data[3*DW +: DW] = 19'h2ABCD;
        #1;
        checks++; if (bus0.req_ready !== 4'b1000) begin errors++; $display("FAIL mid_after_ready: got %b expected 1000", bus0.req_ready); end
        for (int c = 1; c <= 3; c++) begin
            cyc();
            bus0.req_valid = 4'h0;
            #1;
            if (c < 3) begin
                checks++; if (bus0.out_valid !== 1'b0) begin errors++; $display("FAIL mid_stale c+%0d: got %b expected 0", c, bus0.out_valid); end
            end else begin
                checks++; if (bus0.out_valid !== 1'b1 || bus0.out_src !== 2'd3 || bus0.out_code !== ftf_enc(19'h2ABCD)) begin
                    errors++; $display("FAIL mid_after_out: got v=%b src=%0d code=%h expected v=1 src=3 code=%h", bus0.out_valid, bus0.out_src, bus0.out_code, ftf_enc(19'h2ABCD));
                end
                $display("mid: out src=%0d code=%h", bus0.out_src, bus0.out_code);
            end
        end
        cyc();
        #1;
        checks++; if (bus0.enc_count !== 16'd1) begin errors++; $display("FAIL mid_count_post: got %0d expected 1", bus0.enc_count); end
    endtask

    // Same random traffic into the 4-deep and 1-deep instances; in-order scoreboard each.
    task automatic test_random();
        logic [29:0] q0[$];
        logic [29:0] q1[$];
        logic [29:0] e;
        int occ0 = 0;
        int occ1 = 0;
        int del1 = 0;
        for (int n = 0; n < 3000; n++) begin
            cyc();
            if (n < 2950) begin
                bus0.req_valid = 4'($urandom);
                bus0.out_ready = ($urandom_range(0, 3) != 0);
            end else begin
                bus0.req_valid = 4'h0;
                bus0.out_ready = 1'b1;
            end
            for (int i = 0; i < N; i++) bus0.req_data[i*DW +: DW] = DW'($urandom);
            bus1.req_valid = bus0.req_valid;
            bus1.req_data  = bus0.req_data;
            bus1.out_ready = bus0.out_ready;
            #1;
            for (int i = 0; i < N; i++) begin
                if (bus0.req_valid[i] && bus0.req_ready[i]) begin q0.push_back({2'(i), ftf_enc(bus0.req_data[i*DW +: DW])}); occ0++; end
                if (bus1.req_valid[i] && bus1.req_ready[i]) begin q1.push_back({2'(i), ftf_enc(bus1.req_data[i*DW +: DW])}); occ1++; end
            end
            if (bus0.out_valid && bus0.out_ready) begin
                occ0--;
                e = (q0.size() > 0) ? q0.pop_front() : 30'h3FFFFFFF;
                checks++; if ({bus0.out_src, bus0.out_code} !== e) begin errors++; $display("FAIL rnd4_out n=%0d: got src=%0d code=%h expected src=%0d code=%h", n, bus0.out_src, bus0.out_code, e[29:28], e[27:0]); end
            end
            if (bus1.out_valid && bus1.out_ready) begin
                occ1--;
                del1++;
                e = (q1.size() > 0) ? q1.pop_front() : 30'h3FFFFFFF;
                checks++; if ({bus1.out_src, bus1.out_code} !== e) begin errors++; $display("FAIL rnd1_out n=%0d: got src=%0d code=%h expected src=%0d code=%h", n, bus1.out_src, bus1.out_code, e[29:28], e[27:0]); end
            end
            if ((bus0.req_ready & ~bus0.req_valid) != 4'h0 || $countones(bus0.req_ready) > 1 || occ0 > 4) begin
                checks++; errors++; $display("FAIL rnd4_credit n=%0d: got ready=%b occ=%0d expected one-hot grant, occ<=4", n, bus0.req_ready, occ0);
            end
            if ((bus1.req_ready & ~bus1.req_valid) != 4'h0 || $countones(bus1.req_ready) > 1 || occ1 > 1) begin
                checks++; errors++; $display("FAIL rnd1_credit n=%0d: got ready=%b occ=%0d expected one-hot grant, occ<=1", n, bus1.req_ready, occ1);
            end
        end
        checks++; if (q0.size() != 0 || bus0.busy !== 1'b0) begin errors++; $display("FAIL rnd4_drain: got left=%0d busy=%b expected 0 0", q0.size(), bus0.busy); end
        checks++; if (q1.size() != 0 || bus1.busy !== 1'b0) begin errors++; $display("FAIL rnd1_drain: got left=%0d busy=%b expected 0 0", q1.size(), bus1.busy); end
        checks++; if (del1 == 0) begin errors++; $display("FAIL rnd1_progress: got 0 deliveries expected >0"); end
        $display("random: depth1 delivered %0d words", del1);
    endtask

    initial begin
        rst_n          = 1'b0;
        bus0.req_valid = '0;
        bus0.req_data  = '0;
        bus0.out_ready = 1'b0;
        bus1.req_valid = '0;
        bus1.req_data  = '0;
        bus1.out_ready = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_rr_join();
        test_reset_midflight();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
